// File: rtl/wb_burst_master.sv
// -----------------------------------------------------------------------------
// wb_burst_master
//
// Single-port Wishbone B3 initiator. Converts a command (start address, beat
// count, direction) plus a write/read data stream into one incrementing
// Wishbone burst: cti 3'b010 on intermediate beats, 3'b111 on the last beat,
// 3'b000 for single-beat commands, bte always linear.
//
// Ports
//   wb_clk, wb_rst_n          clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o   command handshake (ready only in IDLE)
//   cmd_adr_i, cmd_len_i,     byte start address ([1:0] ignored), beat count,
//   cmd_we_i                  direction (1 = write)
//   wdat_i, wsel_i, wvalid_i  write stream; wready_o pulses per written beat
//   rdat_o, rvalid_o,         read stream; rvalid_o/rdat_o pass through in the
//   rready_i                  ack cycle, rready_i gates the strobe
//   done_o, err_o             one-cycle completion pulse, err_o qualifies it
//   wb_*                      Wishbone B3 initiator signals
//
// Build option
//   WB_BURST_MASTER_TIMEOUT_EN  when defined, a watchdog ends the burst with an
//                               error after TIMEOUT strobed cycles without ack.
// -----------------------------------------------------------------------------
module wb_burst_master #(
  parameter int LEN_WIDTH = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [31:0]          cmd_adr_i,
  input  logic [LEN_WIDTH-1:0] cmd_len_i,
  input  logic                 cmd_we_i,
  input  logic [31:0]          wdat_i,
  input  logic [3:0]           wsel_i,
  input  logic                 wvalid_i,
  output logic                 wready_o,
  output logic [31:0]          rdat_o,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          wb_adr_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  output logic                 wb_we_o,
  output logic [3:0]           wb_sel_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          adr_q, adr_d;
  logic                 we_q, we_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [2:0]           cti_q, cti_d;
  logic                 cyc_q, cyc_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;

  logic in_bus;
  logic stb;
  logic bus_err;
  logic beat_ok;
  logic wd_expired;

  // The strobe follows the data stream so a stalled client simply pauses the
  // burst while cyc stays asserted.
  assign in_bus  = (state_q == BUS);
  assign stb     = in_bus & (we_q ? wvalid_i : rready_i);
  assign bus_err = stb & wb_err_i;
  // An error in the same cycle as ack wins: that beat is not counted.
  assign beat_ok = stb & wb_ack_i & ~wb_err_i;

`ifdef WB_BURST_MASTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (!in_bus || (stb && wb_ack_i) || wb_err_i) begin
      wd_d = '0;
    end else if (stb) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  // Fires on the TIMEOUT-th consecutive unacknowledged strobe cycle.
  assign wd_expired = stb & ~wb_ack_i & ~wb_err_i & (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    adr_d   = adr_q;
    we_d    = we_q;
    rem_d   = rem_q;
    cti_d   = cti_q;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = BUS;
            adr_d   = cmd_adr_i & 32'hFFFF_FFFC;
            we_d    = cmd_we_i;
            rem_d   = cmd_len_i;
            cti_d   = (cmd_len_i == LEN_WIDTH'(1)) ? 3'b000 : 3'b010;
          end
        end
      end
      BUS: begin
        if (bus_err || wd_expired) begin
          state_d = DONE;
          err_d   = 1'b1;
          cti_d   = 3'b000;
        end else if (beat_ok) begin
          adr_d = adr_q + 32'd4;
          rem_d = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) begin
            state_d = DONE;
            cti_d   = 3'b000;
          end else if (rem_q == LEN_WIDTH'(2)) begin
            // The beat after this one is the last of a multi-beat burst.
            cti_d = 3'b111;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus-facing status is registered from the next state so it changes
    // cleanly on the clock edge.
    cyc_d   = (state_d == BUS);
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (!wb_rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      we_q    <= 1'b0;
      rem_q   <= '0;
      cti_q   <= 3'b000;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      rem_q   <= rem_d;
      cti_q   <= cti_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready_o = ready_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wb_adr_o    = adr_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb;
  assign wb_cti_o    = cti_q;
  assign wb_bte_o    = 2'b00;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = we_q ? wsel_i : 4'hF;
  assign wb_dat_o    = wdat_i;
  assign wready_o    = we_q & beat_ok;
  assign rvalid_o    = ~we_q & beat_ok;
  assign rdat_o      = wb_dat_i;

endmodule

// File: tb/tb_wb_burst_master.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_master
//
// Self-checking bench for wb_burst_master. A table of command records drives
// directed bursts; randomized commands follow. A small beat-counting model
// predicts, per cycle, address, cycle type, strobe, stream handshakes and the
// completion status. Hand-written sequences cover command hold during DONE,
// reset in mid-burst and the ack watchdog (or its absence).
// -----------------------------------------------------------------------------
module tb_wb_burst_master;

  localparam int LW = 8;

  logic          wb_clk;
  logic          wb_rst_n;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [31:0]   cmd_adr_i;
  logic [LW-1:0] cmd_len_i;
  logic          cmd_we_i;
  logic [31:0]   wdat_i;
  logic [3:0]    wsel_i;
  logic          wvalid_i;
  logic          wready_o;
  logic [31:0]   rdat_o;
  logic          rvalid_o;
  logic          rready_i;
  logic          done_o;
  logic          err_o;
  logic [31:0]   wb_adr_o;
  logic          wb_cyc_o;
  logic          wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic          wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_dat_o;
  logic [31:0]   wb_dat_i;
  logic          wb_ack_i;
  logic          wb_err_i;

  wb_burst_master #(
    .LEN_WIDTH(LW),
    .TIMEOUT  (16)
  ) dut (
    .wb_clk     (wb_clk),
    .wb_rst_n   (wb_rst_n),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_len_i  (cmd_len_i),
    .cmd_we_i   (cmd_we_i),
    .wdat_i     (wdat_i),
    .wsel_i     (wsel_i),
    .wvalid_i   (wvalid_i),
    .wready_o   (wready_o),
    .rdat_o     (rdat_o),
    .rvalid_o   (rvalid_o),
    .rready_i   (rready_i),
    .done_o     (done_o),
    .err_o      (err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cti_o   (wb_cti_o),
    .wb_bte_o   (wb_bte_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] adr;
    int          len;
    logic        we;
    int          ack_pct;   // chance the slave acks in a cycle
    int          vld_pct;   // chance the client stream is ready in a cycle
    int          err_beat;  // beat index that sees wb_err_i, -1 for none
    int          stall_lo;  // BUS cycles [stall_lo, stall_hi] force the stream low
    int          stall_hi;
    logic        exp_err;
    logic [31:0] exp_end;   // wb_adr_o after completion
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge: registered outputs are
  // settled and inputs changed here are stable for the next edge.
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  // Issues one command from IDLE and follows it to completion, comparing each
  // cycle against a beat-counting model. Returns the DUT's final status and
  // address alongside the model's prediction.
  task automatic run_cmd(input vec_t c, input logic [31:0] prev_adr,
                         output logic act_err, output logic [31:0] act_end,
                         output logic [31:0] model_end);
    logic [31:0] start;
    logic [31:0] d;
    logic        v, a, e, fin, m_err;
    int          k, cyc_n;
    logic [2:0]  exp_cti;

    check("cmd_ready_idle", cmd_ready_o, 1'b1);
    cmd_valid_i = 1'b1;
    cmd_adr_i   = c.adr;
    cmd_len_i   = LW'(c.len);
    cmd_we_i    = c.we;
    tick();
    cmd_valid_i = 1'b0;
    cmd_adr_i   = $urandom;
    cmd_len_i   = LW'($urandom);
    cmd_we_i    = 1'(~c.we);

    start = c.adr & 32'hFFFF_FFFC;
    k     = 0;
    cyc_n = 0;
    m_err = (c.len == 0);
    fin   = (c.len == 0);

    while (!fin) begin
      if (cyc_n >= 3000) begin
        check("bus_cycle_budget", 32'(cyc_n), 32'd0);
        m_err = 1'b1;
        fin   = 1'b1;
        break;
      end
      v = (cyc_n >= c.stall_lo && cyc_n <= c.stall_hi) ? 1'b0
          : ($urandom_range(99) < c.vld_pct);
      a = ($urandom_range(99) < c.ack_pct);
      e = (k == c.err_beat);
      d = $urandom;
      wvalid_i = c.we ? v : 1'($urandom_range(1));
      rready_i = c.we ? 1'($urandom_range(1)) : v;
      wb_ack_i = a;
      wb_err_i = e;
      wb_dat_i = d;
      wdat_i   = $urandom;
      wsel_i   = 4'($urandom);
      #1;
      exp_cti = (c.len == 1) ? 3'b000 : ((c.len - k == 1) ? 3'b111 : 3'b010);
      check("bus_cyc", wb_cyc_o, 1'b1);
      check("bus_adr", wb_adr_o, start + 32'(k) * 32'd4);
      check("bus_cti", wb_cti_o, exp_cti);
      check("bus_we", wb_we_o, c.we);
      check("bus_stb", wb_stb_o, v);
      check("bus_sel", wb_sel_o, c.we ? wsel_i : 4'hF);
      check("bus_dat_o", wb_dat_o, wdat_i);
      check("wready", wready_o, c.we & v & a & ~e);
      check("rvalid", rvalid_o, ~c.we & v & a & ~e);
      if (!c.we && v && a && !e) check("rdat", rdat_o, d);
      if (v && e) begin
        m_err = 1'b1;
        fin   = 1'b1;
      end else if (v && a) begin
        k++;
        if (k == c.len) fin = 1'b1;
      end
      @(posedge wb_clk);
      #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      cyc_n++;
    end

    model_end = (c.len == 0) ? prev_adr : start + 32'(k) * 32'd4;
    check("done_pulse", done_o, 1'b1);
    check("done_err", err_o, m_err);
    check("done_cyc", wb_cyc_o, 1'b0);
    check("done_stb", wb_stb_o, 1'b0);
    check("done_ready", cmd_ready_o, 1'b0);
    check("done_adr", wb_adr_o, model_end);
    act_err = err_o;
    act_end = wb_adr_o;
    wvalid_i = 1'b0;
    rready_i = 1'b0;
    tick();
    check("after_done", done_o, 1'b0);
    check("after_ready", cmd_ready_o, 1'b1);
  endtask

  vec_t        vecs[8];
  logic [31:0] prev, act_end, m_end;
  logic        act_err;

  initial begin
    vecs[0] = '{32'h0000_0100,   8, 1'b0, 100, 100, -1, -1, -1, 1'b0, 32'h0000_0120};
    vecs[1] = '{32'h0000_0200,   1, 1'b1, 100, 100, -1, -1, -1, 1'b0, 32'h0000_0204};
    vecs[2] = '{32'h0000_0300,   4, 1'b1, 100, 100, -1,  2,  3, 1'b0, 32'h0000_0310};
    vecs[3] = '{32'h0000_0400,   8, 1'b0, 100, 100,  2, -1, -1, 1'b1, 32'h0000_0408};
    vecs[4] = '{32'hFFFF_FFFC,   2, 1'b0, 100, 100, -1, -1, -1, 1'b0, 32'h0000_0004};
    vecs[5] = '{32'h0000_0503,   3, 1'b1,  50,  60, -1, -1, -1, 1'b0, 32'h0000_050C};
    vecs[6] = '{32'h0000_0600,   0, 1'b0, 100, 100, -1, -1, -1, 1'b1, 32'h0000_050C};
    vecs[7] = '{32'h0000_1000, 255, 1'b0,  70,  80, -1, -1, -1, 1'b0, 32'h0000_13FC};

    wb_rst_n    = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_adr_i   = '0;
    cmd_len_i   = '0;
    cmd_we_i    = 1'b0;
    wdat_i      = '0;
    wsel_i      = '0;
    wvalid_i    = 1'b0;
    rready_i    = 1'b0;
    wb_dat_i    = '0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_cti", wb_cti_o, 3'b000);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_bte", wb_bte_o, 2'b00);
    check("rst_ready", cmd_ready_o, 1'b1);
    wb_rst_n = 1'b1;
    tick();

    // Directed table
    prev = 32'h0;
    for (int i = 0; i < 8; i++) begin
      run_cmd(vecs[i], prev, act_err, act_end, m_end);
      check($sformatf("tbl%0d_err", i), act_err, vecs[i].exp_err);
      check($sformatf("tbl%0d_end_adr", i), act_end, vecs[i].exp_end);
      prev = m_end;
    end

    // Randomized commands
    for (int i = 0; i < 25; i++) begin
      vec_t r;
      r.adr      = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      r.len      = $urandom_range(12);
      r.we       = 1'($urandom_range(1));
      r.ack_pct  = $urandom_range(100, 30);
      r.vld_pct  = $urandom_range(100, 30);
      r.err_beat = ($urandom_range(3) == 0 && r.len > 0) ? int'($urandom_range(r.len - 1)) : -1;
      r.stall_lo = -1;
      r.stall_hi = -1;
      r.exp_err  = 1'b0;
      r.exp_end  = '0;
      run_cmd(r, prev, act_err, act_end, m_end);
      prev = m_end;
    end

    // A command presented during DONE waits for IDLE
    cmd_valid_i = 1'b1;
    cmd_len_i   = '0;
    tick();
    check("hold_done", done_o, 1'b1);
    check("hold_done_err", err_o, 1'b1);
    cmd_adr_i = 32'h0000_0900;
    cmd_len_i = LW'(2);
    cmd_we_i  = 1'b0;
    rready_i  = 1'b1;
    tick();
    check("hold_idle_cyc", wb_cyc_o, 1'b0);
    check("hold_idle_ready", cmd_ready_o, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
    check("hold_bus_cyc", wb_cyc_o, 1'b1);
    check("hold_bus_adr", wb_adr_o, 32'h0000_0900);
    check("hold_bus_cti", wb_cti_o, 3'b010);
    wb_ack_i = 1'b1;
    tick();
    check("hold_last_cti", wb_cti_o, 3'b111);
    check("hold_last_adr", wb_adr_o, 32'h0000_0904);
    tick();
    wb_ack_i = 1'b0;
    rready_i = 1'b0;
    check("hold_fin_done", done_o, 1'b1);
    check("hold_fin_err", err_o, 1'b0);
    check("hold_fin_adr", wb_adr_o, 32'h0000_0908);
    tick();

    // Reset after the second beat of an 8-beat read
    cmd_valid_i = 1'b1;
    cmd_adr_i   = 32'h0000_0700;
    cmd_len_i   = LW'(8);
    cmd_we_i    = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    rready_i    = 1'b1;
    wb_ack_i    = 1'b1;
    tick();
    tick();
    check("pre_rst_adr", wb_adr_o, 32'h0000_0708);
    wb_rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", wb_cyc_o, 1'b0);
    check("mid_rst_stb", wb_stb_o, 1'b0);
    check("mid_rst_adr", wb_adr_o, 32'h0);
    check("mid_rst_cti", wb_cti_o, 3'b000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_no_done", done_o, 1'b0);
    end
    wb_rst_n = 1'b1;
    wb_ack_i = 1'b0;
    rready_i = 1'b0;
    tick();
    check("post_rst_no_done", done_o, 1'b0);
    begin
      vec_t z;
      z = '{32'h0000_0A00, 0, 1'b0, 100, 100, -1, -1, -1, 1'b1, 32'h0};
      run_cmd(z, 32'h0, act_err, act_end, m_end);
      check("post_rst_len0_err", act_err, 1'b1);
    end

    // Slave never acks
    cmd_valid_i = 1'b1;
    cmd_adr_i   = 32'h0000_0800;
    cmd_len_i   = LW'(4);
    cmd_we_i    = 1'b0;
    tick();
    cmd_valid_i = 1'b0;
    rready_i    = 1'b1;
`ifdef WB_BURST_MASTER_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      check("wd_cyc_held", wb_cyc_o, 1'b1);
      check("wd_no_done", done_o, 1'b0);
      tick();
    end
    check("wd_done", done_o, 1'b1);
    check("wd_err", err_o, 1'b1);
    check("wd_cyc_drop", wb_cyc_o, 1'b0);
    rready_i = 1'b0;
    tick();
    check("wd_ready", cmd_ready_o, 1'b1);
`else
    for (int i = 0; i < 40; i++) begin
      check("stall_cyc_held", wb_cyc_o, 1'b1);
      check("stall_no_done", done_o, 1'b0);
      tick();
    end
    wb_rst_n = 1'b0;
    rready_i = 1'b0;
    tick();
    wb_rst_n = 1'b1;
    tick();
    check("stall_rst_cyc", wb_cyc_o, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
